// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 / SCHIP sprite draw engine.
package chip8_pkg;

  localparam int unsigned DEF_COLS   = 64;
  localparam int unsigned DEF_ROWS   = 32;
  localparam int unsigned DEF_ADDR_W = 12;

  // SCHIP 16x16 sprite geometry
  localparam int unsigned SCHIP_ROWS = 16;
  localparam int unsigned SCHIP_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FB_RD,
    ST_FB_MOD,
    ST_FB_WR,
    ST_DONE
  } state_t;

  // Rows to draw: n, or 16 for an SCHIP sprite (n=0 with wide), or none.
  function automatic logic [4:0] row_count(input logic [3:0] i_n, input logic i_wide);
    if (i_n != 4'd0) return {1'b0, i_n};
    return i_wide ? 5'(SCHIP_ROWS) : 5'd0;
  endfunction

endpackage

// File: rtl/chip8_sprite_shifter.sv
// Places an 8- or 16-pixel sprite row at column x inside a COLS-wide mask,
// either wrapping or clipping pixels that fall past the right edge.
module chip8_sprite_shifter
  import chip8_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS
) (
  input  logic [SCHIP_BITS-1:0]    i_sprite,
  input  logic [$clog2(COLS)-1:0]  i_x,
  input  logic                     i_wide,
  input  logic                     i_clip,
  output logic [COLS-1:0]          o_mask
);

  logic [SCHIP_BITS-1:0] w_aligned;
  logic [SCHIP_BITS-1:0] w_rev;
  logic [2*COLS-1:0]     w_ext;

  // Sprite MSB is the leftmost pixel while mask bit c is column c, so the row
  // is bit-reversed and shifted into a double-width window; the upper half
  // holds the pixels past the right edge, folded back (wrap) or dropped (clip).
  always_comb begin
    w_aligned = i_wide ? i_sprite : {i_sprite[7:0], 8'h00};
    w_rev     = {<<{w_aligned}};
    w_ext     = (2*COLS)'(w_rev) << i_x;
    o_mask    = w_ext[COLS-1:0] | (i_clip ? '0 : w_ext[2*COLS-1:COLS]);
  end

endmodule

// File: rtl/chip8_sprite_engine.sv
// DXYN sprite draw engine: per sprite row, fetch the sprite byte(s), then
// read-modify-write one framebuffer row, accumulating the collision result.
module chip8_sprite_engine
  import chip8_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     ready,
  input  logic [$clog2(COLS)-1:0]  x,
  input  logic [$clog2(ROWS)-1:0]  y,
  input  logic [3:0]               n,
  input  logic [ADDR_W-1:0]        i_base,
  input  logic                     wide_en,
  input  logic                     clip_en,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_valid,
  input  logic [7:0]               mem_rdata,
  output logic [$clog2(ROWS)-1:0]  fb_row,
  output logic                     fb_rd_en,
  input  logic [COLS-1:0]          fb_rdata,
  output logic                     fb_wr_en,
  output logic [COLS-1:0]          fb_wdata,
  output logic                     done,
  output logic                     collision,
  output logic [4:0]               hit_rows
);

  localparam int unsigned XW   = $clog2(COLS);
  localparam int unsigned YW   = $clog2(ROWS);
  localparam int unsigned YB_W = YW + 6;

  state_t                r_state;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [YW-1:0]         r_row;
  logic                  r_wide;
  logic                  r_clip;
  logic                  r_half;
  logic [4:0]            r_nrows;
  logic [4:0]            r_cnt;
  logic [4:0]            r_hit;
  logic [SCHIP_BITS-1:0] r_spr;
  logic [ADDR_W-1:0]     r_addr;
  logic [COLS-1:0]       r_wdata;
  logic                  r_mem_req;
  logic                  r_fb_rd;
  logic                  r_fb_wr;
  logic                  r_done;
  logic                  r_coll;

  logic [4:0]            w_nrows;
  logic [4:0]            w_cnt_nx;
  logic [YB_W-1:0]       w_ybound;
  logic                  w_clip_end;
  logic [COLS-1:0]       w_mask;

  assign w_nrows    = row_count(n, wide_en);
  assign w_cnt_nx   = r_cnt + 5'd1;
  assign w_ybound   = YB_W'(r_y) + YB_W'(w_cnt_nx);
  assign w_clip_end = r_clip && (w_ybound >= YB_W'(ROWS));

  chip8_sprite_shifter #(.COLS(COLS)) u_shifter (
    .i_sprite (r_spr),
    .i_x      (r_x),
    .i_wide   (r_wide),
    .i_clip   (r_clip),
    .o_mask   (w_mask)
  );

  // Draw sequencer; every strobe is a flop updated alongside the state so a
  // reset clears all of them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_row     <= '0;
      r_wide    <= 1'b0;
      r_clip    <= 1'b0;
      r_half    <= 1'b0;
      r_nrows   <= '0;
      r_cnt     <= '0;
      r_hit     <= '0;
      r_spr     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mem_req <= 1'b0;
      r_fb_rd   <= 1'b0;
      r_fb_wr   <= 1'b0;
      r_done    <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_row   <= y;
            r_wide  <= wide_en && (n == 4'd0);
            r_clip  <= clip_en;
            r_nrows <= w_nrows;
            r_cnt   <= '0;
            r_half  <= 1'b0;
            r_addr  <= i_base;
            r_coll  <= 1'b0;
            r_hit   <= '0;
            if (w_nrows == 5'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_FETCH;
              r_mem_req <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (mem_valid) begin
            // One address increment per captured byte gives base+r (narrow)
            // and base+2r, base+2r+1 (wide) without a multiplier.
            r_addr <= r_addr + 1'b1;
            if (r_wide && !r_half) begin
              r_spr[15:8] <= mem_rdata;
              r_half      <= 1'b1;
            end else begin
              if (r_wide) r_spr[7:0] <= mem_rdata;
              else        r_spr      <= {8'h00, mem_rdata};
              r_half    <= 1'b0;
              r_mem_req <= 1'b0;
              r_fb_rd   <= 1'b1;
              r_state   <= ST_FB_RD;
            end
          end
        end
        ST_FB_RD: begin
          r_fb_rd <= 1'b0;
          r_state <= ST_FB_MOD;
        end
        ST_FB_MOD: begin
          r_wdata <= fb_rdata ^ w_mask;
          if ((fb_rdata & w_mask) != '0) begin
            r_coll <= 1'b1;
            if (r_hit != 5'd16) r_hit <= r_hit + 5'd1;
          end
          r_fb_wr <= 1'b1;
          r_state <= ST_FB_WR;
        end
        ST_FB_WR: begin
          r_fb_wr <= 1'b0;
          r_cnt   <= w_cnt_nx;
          r_row   <= r_row + YW'(1);
          if ((w_cnt_nx == r_nrows) || w_clip_end) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= ST_FETCH;
            r_mem_req <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = (r_state == ST_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_addr;
  assign fb_row    = r_row;
  assign fb_rd_en  = r_fb_rd;
  assign fb_wr_en  = r_fb_wr;
  assign fb_wdata  = r_wdata;
  assign done      = r_done;
  assign collision = r_coll;
  assign hit_rows  = r_hit;

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Bench for chip8_sprite_engine: directed test-plan draws plus randomized
// draws compared against a pixel-level reference model of DXYN semantics.
module tb_chip8_sprite_engine;

  localparam int COLS   = 64;
  localparam int ROWS   = 32;
  localparam int ADDR_W = 12;
  localparam int XW     = 6;
  localparam int YW     = 5;
  localparam int MEMSZ  = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start;
  logic              ready;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [3:0]        n;
  logic [ADDR_W-1:0] i_base;
  logic              wide_en;
  logic              clip_en;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [7:0]        mem_rdata;
  logic [YW-1:0]     fb_row;
  logic              fb_rd_en;
  logic [COLS-1:0]   fb_rdata;
  logic              fb_wr_en;
  logic [COLS-1:0]   fb_wdata;
  logic              done;
  logic              collision;
  logic [4:0]        hit_rows;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chip8_sprite_engine #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .n         (n),
    .i_base    (i_base),
    .wide_en   (wide_en),
    .clip_en   (clip_en),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .fb_row    (fb_row),
    .fb_rd_en  (fb_rd_en),
    .fb_rdata  (fb_rdata),
    .fb_wr_en  (fb_wr_en),
    .fb_wdata  (fb_wdata),
    .done      (done),
    .collision (collision),
    .hit_rows  (hit_rows)
  );

  // Sprite memory, framebuffer RAM and activity counters
  logic [7:0]        smem [MEMSZ];
  logic [COLS-1:0]   fb_mem [ROWS];
  logic [COLS-1:0]   fb_seed [ROWS];
  logic              seed_en = 1'b0;
  int                wr_cnt [ROWS];
  int                rd_cnt [ROWS];
  int                overlap = 0;
  int                wcnt = 0;
  int                wait_cfg = 0;
  logic [ADDR_W-1:0] rd_log [$];

  logic [COLS-1:0]   exp_fb [ROWS];
  int                exp_wr [ROWS];

  assign mem_valid = mem_req && (wcnt == wait_cfg);
  assign mem_rdata = smem[mem_addr];

  always @(posedge clk) begin
    if (seed_en) for (int i = 0; i < ROWS; i++) fb_mem[i] <= fb_seed[i];
    if (fb_rd_en) begin
      fb_rdata       <= fb_mem[fb_row];
      rd_cnt[fb_row] <= rd_cnt[fb_row] + 1;
    end
    if (fb_wr_en) begin
      fb_mem[fb_row] <= fb_wdata;
      wr_cnt[fb_row] <= wr_cnt[fb_row] + 1;
    end
    if (fb_rd_en && fb_wr_en) overlap <= overlap + 1;
    if (mem_req && mem_valid) begin
      rd_log.push_back(mem_addr);
      wcnt <= 0;
    end else if (mem_req) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: XOR the sprite pixel by pixel into exp_fb, row limit maxr.
  function automatic void model_draw(input int xx, input int yy, input int nn, input int base,
                                     input bit wen, input bit clip, input int maxr,
                                     output int rows, output int hits);
    int R;
    int W;
    R = (nn != 0) ? nn : (wen ? 16 : 0);
    W = (nn == 0 && wen) ? 16 : 8;
    rows = 0;
    hits = 0;
    for (int r = 0; r < R && r < maxr; r++) begin
      int row;
      bit hit;
      logic [15:0] bits;
      row = yy + r;
      if (clip && row >= ROWS) break;
      row = row % ROWS;
      if (W == 16) bits = {smem[(base + 2*r) % MEMSZ], smem[(base + 2*r + 1) % MEMSZ]};
      else         bits = {smem[(base + r) % MEMSZ], 8'h00};
      hit = 0;
      for (int j = 0; j < W; j++) begin
        int col;
        col = xx + j;
        if (clip && col >= COLS) continue;
        col = col % COLS;
        if (bits[15-j]) begin
          if (exp_fb[row][col]) hit = 1;
          exp_fb[row][col] = ~exp_fb[row][col];
        end
      end
      exp_wr[row]++;
      rows++;
      if (hit) hits++;
    end
  endfunction

  task automatic compare_fb(input string tag, input int wr0[ROWS], input int rd0[ROWS], input bit chk_rd);
    int bad_wr;
    int bad_rd;
    bad_wr = 0;
    bad_rd = 0;
    for (int i = 0; i < ROWS; i++) begin
      check($sformatf("%s fb row%0d", tag, i), fb_mem[i], exp_fb[i]);
      if (wr_cnt[i] - wr0[i] != exp_wr[i]) bad_wr++;
      if (rd_cnt[i] - rd0[i] != exp_wr[i]) bad_rd++;
    end
    check({tag, " write-count rows off"}, bad_wr, 0);
    if (chk_rd) check({tag, " read-count rows off"}, bad_rd, 0);
  endtask

  task automatic draw(input string tag, input int xx, input int yy, input int nn, input int base,
                      input bit wen, input bit clip, input int wt, input bit poke);
    int rows;
    int hits;
    int exp_cyc;
    int cyc;
    int wr0 [ROWS];
    int rd0 [ROWS];
    for (int i = 0; i < ROWS; i++) begin
      wr0[i] = wr_cnt[i];
      rd0[i] = rd_cnt[i];
      exp_wr[i] = 0;
    end
    model_draw(xx, yy, nn, base, wen, clip, 16, rows, hits);
    exp_cyc = rows * (((nn == 0 && wen) ? 2 : 1) * (1 + wt) + 3) + 1;
    wait_cfg = wt;
    @(negedge clk);
    x = XW'(xx); y = YW'(yy); n = 4'(nn); i_base = ADDR_W'(base);
    wide_en = wen; clip_en = clip; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (poke && cyc == 3) begin
        start = 1'b1; x = ~x; n = 4'(nn + 1);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check({tag, " done cycle"}, cyc, exp_cyc);
    check({tag, " collision"}, collision, (hits > 0));
    check({tag, " hit_rows"}, hit_rows, hits);
    @(negedge clk);
    check({tag, " ready/done/mem_req after done"}, {ready, done, mem_req}, 3'b100);
    compare_fb(tag, wr0, rd0, 1'b1);
  endtask

  initial begin : stim
    int li;
    int bad;
    int rows;
    int hits;
    int wr0 [ROWS];
    int rd0 [ROWS];
    start = 0; x = '0; y = '0; n = '0; i_base = '0; wide_en = 0; clip_en = 0;
    for (int i = 0; i < ROWS; i++) begin
      fb_seed[i] = '0;
      exp_fb[i]  = '0;
    end
    for (int i = 0; i < MEMSZ; i++) smem[i] = 8'h00;
    smem[12'h200] = 8'hF0; smem[12'h201] = 8'h90; smem[12'h202] = 8'h90;
    smem[12'h203] = 8'h90; smem[12'h204] = 8'hF0;
    for (int i = 0; i < 4; i++) smem[12'h300 + i] = 8'hFF;
    for (int i = 0; i < 16; i++) smem[12'hFF0 + i] = 8'($urandom);
    for (int i = 0; i < 16; i++) smem[i] = 8'($urandom);
    seed_en = 1'b1;
    repeat (2) @(negedge clk);
    seed_en = 1'b0;

    // reset values while rst_n is held low
    check("reset outputs", {ready, mem_req, fb_rd_en, fb_wr_en, done, collision, hit_rows,
                            fb_row, mem_addr, fb_wdata}, {1'b1, 91'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // digit-0 glyph on a blank framebuffer, then the same draw again
    draw("glyph", 0, 0, 5, 'h200, 0, 0, 0, 0);
    check("glyph row0", fb_mem[0], 64'hF);
    check("glyph row1", fb_mem[1], 64'h9);
    draw("glyph-again", 0, 0, 5, 'h200, 0, 0, 0, 0);
    check("glyph-again row0", fb_mem[0], 64'h0);
    check("glyph-again hit_rows", hit_rows, 5'd5);

    // corner sprite, wrap then clip
    draw("wrap-corner", 60, 30, 4, 'h300, 0, 0, 0, 0);
    check("wrap-corner row1", fb_mem[1], 64'hF00000000000000F);
    draw("clip-corner", 60, 30, 4, 'h300, 0, 1, 0, 0);
    check("clip-corner row30", fb_mem[30], 64'hF);
    check("clip-corner row0", fb_mem[0], 64'hF00000000000000F);

    // SCHIP 16x16 with two wait cycles per byte; sprite addresses wrap past 0xFFF
    li = rd_log.size();
    draw("wide", 50, 20, 0, 'hFF0, 1, 0, 2, 0);
    check("wide byte reads", rd_log.size() - li, 32);
    bad = 0;
    for (int i = 0; i < 32 && li + i < rd_log.size(); i++)
      if (rd_log[li + i] !== ADDR_W'('hFF0 + i)) bad++;
    check("wide read addresses wrong", bad, 0);

    // n=0 without wide draws nothing; start while busy is ignored
    draw("empty", 7, 3, 0, 'h200, 0, 0, 0, 0);
    draw("busy-start", 10, 12, 5, 'h200, 0, 0, 1, 1);

    // reset during FB_MOD of row 2
    for (int i = 0; i < ROWS; i++) begin
      wr0[i] = wr_cnt[i]; rd0[i] = rd_cnt[i]; exp_wr[i] = 0;
    end
    model_draw(5, 29, 5, 'h200, 0, 0, 2, rows, hits);
    wait_cfg = 0;
    @(negedge clk);
    x = XW'(5); y = YW'(29); n = 4'd5; i_base = ADDR_W'('h200); wide_en = 0; clip_en = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-reset row2 read strobe", fb_rd_en, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-reset outputs", {ready, mem_req, fb_rd_en, fb_wr_en, done, collision, hit_rows,
                                fb_row, mem_addr, fb_wdata}, {1'b1, 91'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_fb("mid-reset", wr0, rd0, 1'b0);
    draw("post-reset", 33, 8, 3, 'h200, 0, 0, 0, 0);

    // randomized draws over random sprite memory and framebuffer
    for (int i = 0; i < MEMSZ; i++) smem[i] = 8'($urandom);
    for (int i = 0; i < ROWS; i++) begin
      fb_seed[i] = {$urandom, $urandom} & {$urandom, $urandom};
      exp_fb[i]  = fb_seed[i];
    end
    @(negedge clk);
    seed_en = 1'b1;
    @(negedge clk);
    seed_en = 1'b0;
    for (int k = 0; k < 24; k++) begin
      draw($sformatf("rand%0d", k), int'($urandom_range(0, COLS - 1)),
           int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, MEMSZ - 1)), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 2)), (k % 5) == 0);
    end

    check("rd/wr strobes overlapped", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_engine.md
# chip8_sprite_engine

Parametrised sprite draw engine; successor to the single-row display drawer. On `start` it walks the sprite row by row, fetching each row's sprite bytes over a request/valid memory port and doing a read-modify-write of one framebuffer row at a time through a separate row-wide RAM port. It accumulates the collision result across all rows. Supports CHIP-8 8xN sprites, SCHIP 16x16 sprites, any power-of-two display size, and wrap or clip edge modes. It sits between the CPU's DXYN execute stage, the sprite/program memory and the framebuffer RAM.

## Interface
- `COLS`, 64, display width in pixels; power of two, 16..128
- `ROWS`, 32, display height in rows; power of two, 16..64
- `ADDR_W`, 12, sprite memory address width
- `clk` in 1, system clock
- `rst_n` in 1, reset, asynchronous and active-low
- `start` in 1, draw request; accepted only when `ready`=1
- `ready` out 1, high in IDLE (combinational from state)
- `x` in clog2(COLS), sprite left column; latched at accept
- `y` in clog2(ROWS), sprite top row; latched at accept
- `n` in 4, sprite height; latched at accept
- `i_base` in ADDR_W, sprite start address; latched at accept
- `wide_en` in 1, if set and `n`=0, draw a 16x16 sprite; latched at accept
- `clip_en` in 1, 1 = clip at edges, 0 = wrap; latched at accept
- `mem_req` out 1, sprite byte read request
- `mem_addr` out ADDR_W, byte address, held stable while `mem_req`=1
- `mem_valid` in 1, `mem_rdata` is valid this cycle
- `mem_rdata` in 8, sprite byte
- `fb_row` out clog2(ROWS), framebuffer row address
- `fb_rd_en` out 1, row read strobe; `fb_rdata` is valid the following cycle
- `fb_rdata` in COLS, row contents; bit c = column c
- `fb_wr_en` out 1, row write strobe
- `fb_wdata` out COLS, new row contents
- `done` out 1, one-cycle pulse at the end of a draw
- `collision` out 1, any pixel turned off during the last draw
- `hit_rows` out 5, count of rows that collided in the last draw

## Operation
- States: IDLE, FETCH, FB_RD, FB_MOD, FB_WR, DONE.
- IDLE: on `start`=1, latch all inputs and clear `collision` and `hit_rows`.
  - Starting coordinates are reduced: x mod COLS, y mod ROWS.
  - Row count R = 16 if `n`=0 and `wide_en`=1; 0 if `n`=0 and `wide_en`=0; otherwise `n`.
  - If R=0, go to DONE. Otherwise go to FETCH with r=0.
- FETCH: assert `mem_req` with `mem_addr` = i_base + r (narrow) or i_base + 2r, then i_base + 2r + 1 (wide). Address arithmetic wraps mod 2^ADDR_W.
  - A byte is captured on any edge where `mem_req` and `mem_valid` are both 1. Zero-wait (`mem_valid` in the same cycle as the request) is legal.
  - In wide mode the first byte is the left half (MSB = leftmost pixel).
- FB_RD: `fb_row` = (y + r) mod ROWS, `fb_rd_en`=1.
- FB_MOD: shift the sprite into a COLS-wide mask. Sprite bit 7 (narrow) or bit 15 (wide) maps to column x.
  - Wrap mode: columns ≥ COLS wrap mod COLS.
  - Clip mode: columns ≥ COLS are dropped.
  - Register `fb_rdata` ^ mask. If (`fb_rdata` & mask) ≠ 0, set `collision` and increment `hit_rows` (saturating at 16).
- FB_WR: `fb_wr_en`=1 with the same `fb_row` and registered data. Then r++.
  - If r = R, or clip mode and y + r ≥ ROWS, go to DONE. Otherwise go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `collision` and `hit_rows` hold their values from `done` until the next accepted `start`.
- `start` while `ready`=0 is ignored; it is not queued.
- Reset mid-draw: return to IDLE immediately. A partially drawn sprite is not undone. No strobe may be asserted after reset is asserted.
- Reset values: `ready`=1; all other outputs 0.

## Timing
- Zero-wait memory, narrow sprite: 4 cycles per row.
  - `start` accepted at edge 0; row k occupies cycles 4k+1..4k+4.
  - `done` is high in cycle 4R+1; `ready`=1 in cycle 4R+2.
- Wide sprite: 5 cycles per row at zero wait.
- Each memory wait cycle adds one cycle.
- R=0: `done` in cycle 1.
- `fb_rd_en` and `fb_wr_en` are never asserted in the same cycle.
- Each framebuffer row is read and written exactly once per sprite row.

## Structure
- Shared package `chip8_pkg`: state enum, default COLS/ROWS/ADDR_W, SCHIP sprite constants (16 rows, 16 bits).
- Sub-module `chip8_sprite_shifter`: combinational; inputs 16-bit sprite, x, wide, clip; output COLS-wide mask. Wrap and clip handling live there.

## Test plan
- Blank framebuffer, x=0, y=0, n=5, bytes F0 90 90 90 F0:
  - Rows 0..4 written as 0xF0 patterns at columns 0..3.
  - `collision`=0; `done` in cycle 21.
- Same draw repeated:
  - All five rows return to zero.
  - `collision`=1, `hit_rows`=5.
- x=60, y=30, n=4, all bytes FF, wrap mode:
  - Rows 30, 31, 0, 1 are written.
  - Columns 60..63 and 0..3 are set in each.
- Same coordinates with `clip_en`=1:
  - Only rows 30 and 31 are written, with columns 60..63 set.
  - `done` occurs after 2 rows.
- COLS=128, ROWS=64, `wide_en`=1, n=0:
  - 32 byte reads at i_base..i_base+31.
  - `mem_valid` delayed 2 cycles per byte; each row takes 9 cycles.
  - 16 rows written.
- Assert `rst_n`=0 during the FB_MOD state of row 2:
  - Outputs drop to reset values at once.
  - `fb_wr_en` is not asserted for row 2.
  - A subsequent `start` is accepted normally.
